// File: rtl/mux_21_sel_arb_pkg.sv
// mux_21_sel_arb_pkg
// Shared definitions for the 2:1 mux select arbiter:
//   - state_e  : FSM state encoding (IDLE, OWN_A, OWN_B, GUARD)
//   - SEL_A/B  : mux select encoding, also used to name an owner/target
//   - GUARD_W  : width of the guard-interval counter (DEAD_CYC <= 15)
//   - rr_winner: round-robin winner between the two requesters
package mux_21_sel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    GUARD = 2'd3
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int unsigned GUARD_W = 4;

  // Owners are encoded like sel, so the tie-break winner is simply
  // the side that did not own the mux last.
  function automatic logic rr_winner(input logic req_a,
                                     input logic req_b,
                                     input logic last_owner);
    if (req_a && req_b) begin
      return ~last_owner;
    end else if (req_b) begin
      return SEL_B;
    end else begin
      return SEL_A;
    end
  endfunction

endpackage

// File: rtl/mux_21_sel_arb_sat_counter.sv
// sat_counter
// Up-counter with synchronous clear, enable and saturation at all-ones.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (count -> 0)
//   clr_i  : restart the count; together with en_i the restart counts the
//            current cycle, so the counter reads 1 on the following cycle
//   en_i   : increment (holds at 2^W-1)
//   cnt_o  : current count
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: restart, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = en_i ? W'(1) : '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mux_21_sel_arb.sv
// mux_21_sel_arb
// Round-robin arbiter driving the select line of a 2:1 mux. Whenever sel
// changes, DEAD_CYC guard cycles with no grant are inserted before the new
// owner is granted. Under contention an owner keeps the mux for at least
// max(1, hold_cnt) cycles (hold_cnt latched at grant start).
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset
//   req_a/b  : level-sensitive requests for the in_a / in_b path
//   hold_cnt : minimum dwell under contention, latched on grant start
//   sel      : mux select (0 = in_a, 1 = in_b), registered
//   gnt_a/b  : ownership grants, registered, mutually exclusive
//   guard    : high during guard cycles, registered
module mux_21_sel_arb
  import mux_21_sel_arb_pkg::*;
#(
  parameter int unsigned HOLD_W   = 4,
  parameter int unsigned DEAD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic              sel,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              guard
);

  localparam logic [GUARD_W-1:0] DEAD_LAST = GUARD_W'(DEAD_CYC);

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                gnt_a_q, gnt_a_d;
  logic                gnt_b_q, gnt_b_d;
  logic                guard_q, guard_d;
  logic                last_q, last_d;
  logic                target_q, target_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [HOLD_W-1:0]   dwell_s;
  logic [GUARD_W-1:0]  gcnt_s;
  logic                dwell_clr_s, dwell_en_s;
  logic                gcnt_clr_s, gcnt_en_s;
  logic                win_s;
  logic                go_own_s, go_guard_s, go_idle_s;
  logic                who_s;

  assign win_s = rr_winner(req_a, req_b, last_q);

  // Transition decision: which state to enter next and for which side.
  always_comb begin
    go_own_s   = 1'b0;
    go_guard_s = 1'b0;
    go_idle_s  = 1'b0;
    who_s      = sel_q;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          who_s = win_s;
          if (win_s == sel_q) begin
            go_own_s = 1'b1;
          end else begin
            go_guard_s = 1'b1;
          end
        end else begin
          go_own_s = 1'b0;
        end
      end
      OWN_A: begin
        // Release and preemption both hand over through GUARD when B waits.
        if (!req_a) begin
          if (req_b) begin
            go_guard_s = 1'b1;
            who_s      = SEL_B;
          end else begin
            go_idle_s = 1'b1;
          end
        end else if (req_b && (dwell_s >= hold_q)) begin
          go_guard_s = 1'b1;
          who_s      = SEL_B;
        end else begin
          go_own_s = 1'b0;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          if (req_a) begin
            go_guard_s = 1'b1;
            who_s      = SEL_A;
          end else begin
            go_idle_s = 1'b1;
          end
        end else if (req_a && (dwell_s >= hold_q)) begin
          go_guard_s = 1'b1;
          who_s      = SEL_A;
        end else begin
          go_own_s = 1'b0;
        end
      end
      GUARD: begin
        if (gcnt_s >= DEAD_LAST) begin
          who_s = target_q;
          if ((target_q == SEL_A) ? req_a : req_b) begin
            go_own_s = 1'b1;
          end else begin
            go_idle_s = 1'b1;
          end
        end else begin
          go_own_s = 1'b0;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase
  end

  // Next-state values for the FSM and its registered outputs.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    gnt_a_d  = gnt_a_q;
    gnt_b_d  = gnt_b_q;
    guard_d  = guard_q;
    last_d   = last_q;
    target_d = target_q;
    hold_d   = hold_q;
    if (go_own_s) begin
      state_d = (who_s == SEL_A) ? OWN_A : OWN_B;
      gnt_a_d = (who_s == SEL_A);
      gnt_b_d = (who_s == SEL_B);
      guard_d = 1'b0;
      hold_d  = hold_cnt;
      last_d  = who_s;
    end else if (go_guard_s) begin
      state_d  = GUARD;
      sel_d    = who_s;
      target_d = who_s;
      gnt_a_d  = 1'b0;
      gnt_b_d  = 1'b0;
      guard_d  = 1'b1;
    end else if (go_idle_s) begin
      state_d = IDLE;
      gnt_a_d = 1'b0;
      gnt_b_d = 1'b0;
      guard_d = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // Counters restart on entry so they read 1 during the first cycle.
  assign dwell_clr_s = go_own_s;
  assign dwell_en_s  = go_own_s || (state_q == OWN_A) || (state_q == OWN_B);
  assign gcnt_clr_s  = go_guard_s;
  assign gcnt_en_s   = go_guard_s || (state_q == GUARD);

  sat_counter #(.W(HOLD_W)) u_dwell (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (dwell_clr_s),
    .en_i  (dwell_en_s),
    .cnt_o (dwell_s)
  );

  sat_counter #(.W(GUARD_W)) u_guard (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (gcnt_clr_s),
    .en_i  (gcnt_en_s),
    .cnt_o (gcnt_s)
  );

  // FSM state and output registers; last owner resets to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= SEL_A;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      guard_q  <= 1'b0;
      last_q   <= SEL_B;
      target_q <= SEL_A;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      guard_q  <= guard_d;
      last_q   <= last_d;
      target_q <= target_d;
      hold_q   <= hold_d;
    end
  end

  assign sel   = sel_q;
  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign guard = guard_q;

endmodule
